// File: rtl/mips_regfile_mp_pkg.sv
// Shared constants and types for the multi-port MIPS register file.
package mips_regfile_mp_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_AW     = 5;
  localparam int DEFAULT_NUM_RD = 2;

  // Where a read port takes its data from, in decreasing priority.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_WR1  = 2'd1,
    SRC_WR0  = 2'd2,
    SRC_REG  = 2'd3
  } rd_src_e;

endpackage

// File: rtl/mips_regfile_mp_read_port.sv
// One combinational read port: zero-register override, same-cycle write
// bypass (port 1 before port 0), and the matching busy indication.
module mips_regfile_mp_read_port
  import mips_regfile_mp_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int AW       = DEFAULT_AW,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]    regnum,
  input  logic [WIDTH-1:0] stored_data,
  input  logic             stored_busy,
  input  logic             wr0_en,
  input  logic [AW-1:0]    wr0_regnum,
  input  logic [WIDTH-1:0] wr0_data,
  input  logic             wr1_en,
  input  logic [AW-1:0]    wr1_regnum,
  input  logic [WIDTH-1:0] wr1_data,
  output logic [WIDTH-1:0] data,
  output logic             busy
);

  rd_src_e src;

  // Pick the data source; a hardwired zero register beats any bypass.
  always_comb begin
    src = SRC_REG;
    if ((ZERO_REG != 0) && (regnum == '0))
      src = SRC_ZERO;
    else if (wr1_en && (wr1_regnum == regnum))
      src = SRC_WR1;
    else if (wr0_en && (wr0_regnum == regnum))
      src = SRC_WR0;
  end

  // Steer data; a register being written this cycle is no longer busy.
  always_comb begin
    data = stored_data;
    busy = 1'b0;
    case (src)
      SRC_ZERO: data = '0;
      SRC_WR1:  data = wr1_data;
      SRC_WR0:  data = wr0_data;
      SRC_REG: begin
        data = stored_data;
        busy = stored_busy;
      end
      default: begin
        data = stored_data;
        busy = stored_busy;
      end
    endcase
  end

endmodule

// File: rtl/mips_regfile_mp.sv
// Parametrised register file: NUM_RD bypassed read ports, two prioritised
// write ports and a per-register busy scoreboard for multi-cycle producers.
module mips_regfile_mp
  import mips_regfile_mp_pkg::*;
#(
  parameter int              WIDTH       = DEFAULT_WIDTH,
  parameter int              DEPTH       = DEFAULT_DEPTH,
  parameter int              AW          = DEFAULT_AW,
  parameter int              NUM_RD      = DEFAULT_NUM_RD,
  parameter int              ZERO_REG    = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RD*AW-1:0]    rd_regnum,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    wr0_en,
  input  logic [AW-1:0]           wr0_regnum,
  input  logic [WIDTH-1:0]        wr0_data,
  input  logic                    wr1_en,
  input  logic [AW-1:0]           wr1_regnum,
  input  logic [WIDTH-1:0]        wr1_data,
  input  logic                    alloc_en,
  input  logic [AW-1:0]           alloc_regnum
);

  logic [DEPTH-1:0][WIDTH-1:0] reg_q;
  logic [DEPTH-1:0]            busy_q;

  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(r);

    if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
      // Hardwired zero: never written, never allocated.
      assign reg_q[r]  = '0;
      assign busy_q[r] = 1'b0;
    end else begin : g_live
      logic [WIDTH-1:0] q;
      logic             b;
      logic             hit0;
      logic             hit1;
      logic             hit_alloc;

      assign hit0      = wr0_en && (wr0_regnum == IDX);
      assign hit1      = wr1_en && (wr1_regnum == IDX);
      assign hit_alloc = alloc_en && (alloc_regnum == IDX);

      // Store data (port 1 wins) and track busy (a new alloc beats a retiring write).
      always_ff @(posedge clk) begin
        if (reset) begin
          q <= RESET_VALUE;
          b <= 1'b0;
        end else begin
          if (hit1)
            q <= wr1_data;
          else if (hit0)
            q <= wr0_data;
          if (hit_alloc)
            b <= 1'b1;
          else if (hit0 || hit1)
            b <= 1'b0;
        end
      end

      assign reg_q[r]  = q;
      assign busy_q[r] = b;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_regnum[i*AW +: AW];

    mips_regfile_mp_read_port #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .regnum      (addr),
      .stored_data (reg_q[addr]),
      .stored_busy (busy_q[addr]),
      .wr0_en      (wr0_en),
      .wr0_regnum  (wr0_regnum),
      .wr0_data    (wr0_data),
      .wr1_en      (wr1_en),
      .wr1_regnum  (wr1_regnum),
      .wr1_data    (wr1_data),
      .data        (rd_data[i*WIDTH +: WIDTH]),
      .busy        (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Bench for mips_regfile_mp: a default 32-bit/2-port/zero-register instance
// and a 16-bit/4-port/no-zero-register instance share one stimulus stream
// and are compared against an array-based reference model.
module tb_mips_regfile_mp;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_addr [4];
  logic        wr0_en;
  logic [4:0]  wr0_regnum;
  logic [31:0] wr0_data;
  logic        wr1_en;
  logic [4:0]  wr1_regnum;
  logic [31:0] wr1_data;
  logic        alloc_en;
  logic [4:0]  alloc_regnum;

  logic [9:0]  rd_regnum_a;
  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [19:0] rd_regnum_b;
  logic [63:0] rd_data_b;
  logic [3:0]  rd_busy_b;

  int checks;
  int failures;

  // Reference model: index 0 = zero-register config, 1 = plain config.
  logic [31:0] mem  [2][32];
  bit          busy [2][32];

  assign rd_regnum_a = {rd_addr[1], rd_addr[0]};
  assign rd_regnum_b = {rd_addr[3], rd_addr[2], rd_addr[1], rd_addr[0]};

  mips_regfile_mp dut_a (
    .clk          (clk),
    .reset        (reset),
    .rd_regnum    (rd_regnum_a),
    .rd_data      (rd_data_a),
    .rd_busy      (rd_busy_a),
    .wr0_en       (wr0_en),
    .wr0_regnum   (wr0_regnum),
    .wr0_data     (wr0_data),
    .wr1_en       (wr1_en),
    .wr1_regnum   (wr1_regnum),
    .wr1_data     (wr1_data),
    .alloc_en     (alloc_en),
    .alloc_regnum (alloc_regnum)
  );

  mips_regfile_mp #(
    .WIDTH    (16),
    .NUM_RD   (4),
    .ZERO_REG (0)
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .rd_regnum    (rd_regnum_b),
    .rd_data      (rd_data_b),
    .rd_busy      (rd_busy_b),
    .wr0_en       (wr0_en),
    .wr0_regnum   (wr0_regnum),
    .wr0_data     (wr0_data[15:0]),
    .wr1_en       (wr1_en),
    .wr1_regnum   (wr1_regnum),
    .wr1_data     (wr1_data[15:0]),
    .alloc_en     (alloc_en),
    .alloc_regnum (alloc_regnum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] expData(input int c, input logic [4:0] a);
    if (c == 0 && a == 5'd0) return 32'd0;
    if (wr1_en && wr1_regnum == a) return wr1_data;
    if (wr0_en && wr0_regnum == a) return wr0_data;
    return mem[c][a];
  endfunction

  function automatic logic expBusy(input int c, input logic [4:0] a);
    if (c == 0 && a == 5'd0) return 1'b0;
    if ((wr1_en && wr1_regnum == a) || (wr0_en && wr0_regnum == a)) return 1'b0;
    return busy[c][a];
  endfunction

  function automatic logic [4:0] randAddr();
    logic [4:0] a;
    if ($urandom_range(0, 2) == 0) a = 5'($urandom_range(0, 3));
    else a = 5'($urandom_range(0, 31));
    return a;
  endfunction

  task automatic updateModel();
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        for (int r = 0; r < 32; r++) begin
          mem[c][r]  = 32'd0;
          busy[c][r] = 1'b0;
        end
      end else begin
        if (wr0_en && !(c == 0 && wr0_regnum == 5'd0)) begin
          mem[c][wr0_regnum]  = wr0_data;
          busy[c][wr0_regnum] = 1'b0;
        end
        if (wr1_en && !(c == 0 && wr1_regnum == 5'd0)) begin
          mem[c][wr1_regnum]  = wr1_data;
          busy[c][wr1_regnum] = 1'b0;
        end
        if (alloc_en && !(c == 0 && alloc_regnum == 5'd0))
          busy[c][alloc_regnum] = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                               input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                               input logic ae, input logic [4:0] aa);
    reset        = rst;
    wr0_en       = w0e;
    wr0_regnum   = w0a;
    wr0_data     = w0d;
    wr1_en       = w1e;
    wr1_regnum   = w1a;
    wr1_data     = w1d;
    alloc_en     = ae;
    alloc_regnum = aa;
  endtask

  task automatic setReads(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
    rd_addr[0] = a0;
    rd_addr[1] = a1;
    rd_addr[2] = a2;
    rd_addr[3] = a3;
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] e;
    logic        eb;
    #1;
    for (int i = 0; i < 2; i++) begin
      e  = expData(0, rd_addr[i]);
      eb = expBusy(0, rd_addr[i]);
      checks++;
      assert (rd_data_a[i*32 +: 32] === e) else begin
        failures++;
        $error("[TB] FAIL %s a.data%0d reg%0d got=%h exp=%h", tag, i, rd_addr[i], rd_data_a[i*32 +: 32], e);
      end
      checks++;
      assert (rd_busy_a[i] === eb) else begin
        failures++;
        $error("[TB] FAIL %s a.busy%0d reg%0d got=%b exp=%b", tag, i, rd_addr[i], rd_busy_a[i], eb);
      end
    end
    for (int i = 0; i < 4; i++) begin
      e  = expData(1, rd_addr[i]);
      eb = expBusy(1, rd_addr[i]);
      checks++;
      assert (rd_data_b[i*16 +: 16] === e[15:0]) else begin
        failures++;
        $error("[TB] FAIL %s b.data%0d reg%0d got=%h exp=%h", tag, i, rd_addr[i], rd_data_b[i*16 +: 16], e[15:0]);
      end
      checks++;
      assert (rd_busy_b[i] === eb) else begin
        failures++;
        $error("[TB] FAIL %s b.busy%0d reg%0d got=%b exp=%b", tag, i, rd_addr[i], rd_busy_b[i], eb);
      end
    end
  endtask

  // Optionally check the current cycle, then clock the DUTs and the model.
  task automatic cycle(input string tag, input bit doCheck);
    if (doCheck) checkOutput(tag);
    @(posedge clk);
    updateModel();
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++) begin
        mem[c][r]  = 32'd0;
        busy[c][r] = 1'b0;
      end

    $display("[TB] reset sequence");
    setReads(5'd0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle("reset", 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      setReads(5'(a), 5'(31 - a), 5'(a), 5'(31 - a));
      cycle("after_reset", 1'b1);
    end

    $display("[TB] basic write and bypass");
    setReads(5'd5, 5'd6, 5'd5, 5'd6);
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle("wr_bypass", 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle("wr_stored", 1'b1);

    $display("[TB] dual-write collision");
    setReads(5'd7, 5'd3, 5'd4, 5'd7);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'hAAAA_AAAA, 1'b1, 5'd7, 32'h5555_5555, 1'b0, 5'd0);
    cycle("collide_bypass", 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle("collide_stored", 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h3333_0003, 1'b1, 5'd4, 32'h4444_0004, 1'b0, 5'd0);
    cycle("dual_bypass", 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle("dual_stored", 1'b1);

    $display("[TB] zero register");
    setReads(5'd0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    cycle("zero_same", 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle("zero_next", 1'b1);

    $display("[TB] scoreboard");
    setReads(5'd9, 5'd9, 5'd9, 5'd9);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    cycle("alloc_same", 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle("alloc_next", 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999_0001, 1'b0, 5'd0);
    cycle("retire_same", 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle("retire_next", 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h9999_0002, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    cycle("alloc_wr_same", 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle("alloc_wr_next", 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    cycle("realloc", 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle("realloc_next", 1'b1);

    $display("[TB] reset mid-operation");
    setReads(5'd12, 5'd9, 5'd5, 5'd7);
    applyStimulus(1'b1, 1'b1, 5'd12, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
    cycle("reset_bypass", 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle("reset_after", 1'b1);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      setReads(randAddr(), randAddr(), randAddr(), randAddr());
      applyStimulus(($urandom_range(0, 49) == 0),
                    1'($urandom_range(0, 1)), randAddr(), $urandom(),
                    1'($urandom_range(0, 1)), randAddr(), $urandom(),
                    1'($urandom_range(0, 2) == 0), randAddr());
      cycle("random", 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
